// File: rtl/rst_seq_gen_if.sv
// Reset request inputs and sequenced reset outputs for one clock domain.
interface rst_seq_gen_if;
    logic       ext_reset_in;
    logic       aux_reset_in;
    logic       mb_debug_sys_rst;
    logic       dcm_locked;
    logic       bus_struct_reset;
    logic [0:0] interconnect_aresetn;
    logic [0:0] peripheral_aresetn;
    logic       peripheral_reset;
    logic       rst_done;

    // Request source side: drives the async requests, watches the resets
    modport master (
        output ext_reset_in, aux_reset_in, mb_debug_sys_rst, dcm_locked,
        input  bus_struct_reset, interconnect_aresetn, peripheral_aresetn,
               peripheral_reset, rst_done
    );

    // Sequencer side
    modport slave (
        input  ext_reset_in, aux_reset_in, mb_debug_sys_rst, dcm_locked,
        output bus_struct_reset, interconnect_aresetn, peripheral_aresetn,
               peripheral_reset, rst_done
    );
endinterface

// File: rtl/rst_seq_gen.sv
// Per-domain reset sequencer: synchronizes and filters reset requests, then
// releases bus, interconnect and peripheral resets in order after a hold.
module rst_seq_gen #(
    parameter bit EXT_RST_ACTIVE_HIGH = 1'b1,
    parameter bit AUX_RST_ACTIVE_HIGH = 1'b0,
    parameter int SYNC_STAGES         = 3,
    parameter int EXT_FILTER          = 4,
    parameter int HOLD_CYCLES         = 16,
    parameter int RELEASE_GAP         = 4
) (
    input  logic         aclk,
    input  logic         aresetn,
    rst_seq_gen_if.slave rif
);
    localparam int MAX_HG = (HOLD_CYCLES > RELEASE_GAP) ? HOLD_CYCLES : RELEASE_GAP;
    localparam int MAX_V  = (MAX_HG > EXT_FILTER) ? MAX_HG : EXT_FILTER;
    localparam int CW     = $clog2(MAX_V + 1);

    localparam logic [CW-1:0] FILT_MAX  = CW'(EXT_FILTER);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(RELEASE_GAP - 1);

    // Request index: 0 ext, 1 aux, 2 debug, 3 clock not locked
    localparam int N_REQ = 4;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HOLD,
        ST_REL_BUS,
        ST_REL_IC,
        ST_RUN
    } state_e;

    logic [N_REQ-1:0]                  req_raw;
    logic [N_REQ-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0]            prime_q, prime_d;
    logic [1:0][CW-1:0]                fcnt_q, fcnt_d;
    state_e                            state_q, state_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic                              bus_q, bus_d;
    logic                              ic_q, ic_d;
    logic                              per_q, per_d;
    logic                              done_q, done_d;
    logic                              ext_f, aux_f, req;

    // Normalize every request input to active-high
    assign req_raw[0] = EXT_RST_ACTIVE_HIGH ? rif.ext_reset_in : ~rif.ext_reset_in;
    assign req_raw[1] = AUX_RST_ACTIVE_HIGH ? rif.aux_reset_in : ~rif.aux_reset_in;
    assign req_raw[2] = rif.mb_debug_sys_rst;
    assign req_raw[3] = ~rif.dcm_locked;

    // Synchronizer shift; prime tracks which sync stages hold real samples
    // rather than the request-active reset preload, so the filters never
    // count the preload as a genuine ext/aux request.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], req_raw[i]};
        end
        prime_d = {prime_q[SYNC_STAGES-2:0], 1'b1};
    end

    // Glitch filter for ext/aux: saturating run-length of active samples
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i][SYNC_STAGES-1] && prime_q[SYNC_STAGES-1]) begin
                fcnt_d[i] = (fcnt_q[i] == FILT_MAX) ? fcnt_q[i] : fcnt_q[i] + 1'b1;
            end else begin
                fcnt_d[i] = '0;
            end
        end
    end

    assign ext_f = (fcnt_q[0] == FILT_MAX);
    assign aux_f = (fcnt_q[1] == FILT_MAX);
    assign req   = ext_f | aux_f | sync_q[2][SYNC_STAGES-1] | sync_q[3][SYNC_STAGES-1];

    // Sequencer next state; any request wins over a completing count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_REL_BUS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REL_BUS: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_REL_IC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REL_IC: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
        if (req) begin
            state_d = ST_RESET;
            cnt_d   = '0;
        end
    end

    // Output decode from the next state so outputs change on the transition edge
    always_comb begin
        bus_d  = (state_d == ST_RESET) || (state_d == ST_HOLD);
        ic_d   = (state_d == ST_REL_IC) || (state_d == ST_RUN);
        per_d  = (state_d == ST_RUN);
        done_d = (state_d == ST_RUN);
    end

    // State, synchronizer, filter and output registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sync_q  <= '1;
            prime_q <= '0;
            fcnt_q  <= '0;
            state_q <= ST_RESET;
            cnt_q   <= '0;
            bus_q   <= 1'b1;
            ic_q    <= 1'b0;
            per_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prime_q <= prime_d;
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            ic_q    <= ic_d;
            per_q   <= per_d;
            done_q  <= done_d;
        end
    end

    assign rif.bus_struct_reset     = bus_q;
    assign rif.interconnect_aresetn = ic_q;
    assign rif.peripheral_aresetn   = per_q;
    assign rif.peripheral_reset     = ~per_q;
    assign rif.rst_done             = done_q;
endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: default instance plus a minimum-parameter instance,
// checked against an edge-history reference model.
module tb_rst_seq_gen;
    localparam int HMAX = 8192;

    logic aclk = 1'b0;
    logic aresetn0, aresetn1;
    int   errors = 0;
    int   checks = 0;

    always #5 aclk = ~aclk;

    rst_seq_gen_if if0 ();
    rst_seq_gen_if if1 ();

    rst_seq_gen dut0 (
        .aclk    (aclk),
        .aresetn (aresetn0),
        .rif     (if0)
    );

    rst_seq_gen #(
        .EXT_RST_ACTIVE_HIGH (1'b1),
        .AUX_RST_ACTIVE_HIGH (1'b0),
        .SYNC_STAGES         (2),
        .EXT_FILTER          (1),
        .HOLD_CYCLES         (1),
        .RELEASE_GAP         (1)
    ) dut1 (
        .aclk    (aclk),
        .aresetn (aresetn1),
        .rif     (if1)
    );

    // {bus_struct_reset, interconnect_aresetn, peripheral_aresetn, peripheral_reset, rst_done}
    wire [4:0] obs0 = {if0.bus_struct_reset, if0.interconnect_aresetn, if0.peripheral_aresetn,
                       if0.peripheral_reset, if0.rst_done};
    wire [4:0] obs1 = {if1.bus_struct_reset, if1.interconnect_aresetn, if1.peripheral_aresetn,
                       if1.peripheral_reset, if1.rst_done};

    // ---------------- reference model ----------------
    // h_*[d][n] = active-high input value seen at edge n after reset release.
    // k_e = number of consecutive edges whose decision saw no request; the
    // phase of the release sequence follows from k alone.
    int S_P [2] = '{3, 2};
    int F_P [2] = '{4, 1};
    int H_P [2] = '{16, 1};
    int G_P [2] = '{4, 1};
    int n_e [2];
    int k_e [2];
    bit h_ext [2][HMAX];
    bit h_aux [2][HMAX];
    bit h_dbg [2][HMAX];
    bit h_nl  [2][HMAX];

    function automatic bit model_req(int d, int n);
        int idx;
        bit r, ea, aa;
        idx = n - S_P[d];
        if (idx < 1) return 1'b1;
        r = h_dbg[d][idx] | h_nl[d][idx];
        if (idx - F_P[d] >= 1) begin
            ea = 1'b1;
            aa = 1'b1;
            for (int j = idx - F_P[d]; j <= idx - 1; j++) begin
                ea = ea & h_ext[d][j];
                aa = aa & h_aux[d][j];
            end
            r = r | ea | aa;
        end
        return r;
    endfunction

    function automatic logic [4:0] exp_out(int d);
        logic bus, ic, per;
        bus = (k_e[d] <= H_P[d]);
        ic  = (k_e[d] > H_P[d] + G_P[d]);
        per = (k_e[d] > H_P[d] + 2 * G_P[d]);
        return {bus, ic, per, ~per, per};
    endfunction

    always @(posedge aclk) begin
        for (int d = 0; d < 2; d++) begin
            bit rn, ex, ax, db, nl;
            if (d == 0) begin
                rn = aresetn0; ex = if0.ext_reset_in; ax = ~if0.aux_reset_in;
                db = if0.mb_debug_sys_rst; nl = ~if0.dcm_locked;
            end else begin
                rn = aresetn1; ex = if1.ext_reset_in; ax = ~if1.aux_reset_in;
                db = if1.mb_debug_sys_rst; nl = ~if1.dcm_locked;
            end
            if (!rn) begin
                n_e[d] = 0;
                k_e[d] = 0;
            end else if (n_e[d] < HMAX - 1) begin
                n_e[d] = n_e[d] + 1;
                if (model_req(d, n_e[d])) k_e[d] = 0;
                else if (k_e[d] < 100000) k_e[d] = k_e[d] + 1;
                h_ext[d][n_e[d]] = ex;
                h_aux[d][n_e[d]] = ax;
                h_dbg[d][n_e[d]] = db;
                h_nl[d][n_e[d]]  = nl;
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset;
        aresetn0 = 1'b0; aresetn1 = 1'b0;
        if0.ext_reset_in = 1'b0; if0.aux_reset_in = 1'b1;
        if0.mb_debug_sys_rst = 1'b0; if0.dcm_locked = 1'b1;
        if1.ext_reset_in = 1'b0; if1.aux_reset_in = 1'b1;
        if1.mb_debug_sys_rst = 1'b0; if1.dcm_locked = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if (obs0 !== 5'b10010) begin
            errors++; $display("FAIL reset_vals_dut0 got=%b want=%b", obs0, 5'b10010);
        end
        checks++;
        if (obs1 !== 5'b10010) begin
            errors++; $display("FAIL reset_vals_dut1 got=%b want=%b", obs1, 5'b10010);
        end
    endtask

    task automatic test_powerup;
        int t_bus, t_ic, t_per, t_done;
        t_bus = -1; t_ic = -1; t_per = -1; t_done = -1;
        aresetn0 = 1'b1;
        repeat (40) begin
            @(negedge aclk);
            checks++;
            if (obs0 !== exp_out(0)) begin
                errors++; $display("FAIL powerup_seq edge=%0d got=%b want=%b", n_e[0], obs0, exp_out(0));
            end
            if (t_bus < 0 && obs0[4] == 1'b0) t_bus = n_e[0];
            if (t_ic < 0 && obs0[3] == 1'b1) t_ic = n_e[0];
            if (t_per < 0 && obs0[2] == 1'b1 && obs0[1] == 1'b0) t_per = n_e[0];
            if (t_done < 0 && obs0[0] == 1'b1) t_done = n_e[0];
        end
        checks++;
        if (t_bus != 20) begin errors++; $display("FAIL powerup_bus_edge got=%0d want=20", t_bus); end
        checks++;
        if (t_ic != 24) begin errors++; $display("FAIL powerup_ic_edge got=%0d want=24", t_ic); end
        checks++;
        if (t_per != 28) begin errors++; $display("FAIL powerup_per_edge got=%0d want=28", t_per); end
        checks++;
        if (t_done != 28) begin errors++; $display("FAIL powerup_done_edge got=%0d want=28", t_done); end
    endtask

    task automatic test_ext_filter;
        int p, t_as, t_rel;
        // 3-cycle pulse: shorter than the filter, must be ignored
        if0.ext_reset_in = 1'b1;
        repeat (3) @(negedge aclk);
        if0.ext_reset_in = 1'b0;
        repeat (20) begin
            @(negedge aclk);
            checks++;
            if (obs0 !== 5'b01101) begin
                errors++; $display("FAIL ext3_ignored edge=%0d got=%b want=%b", n_e[0], obs0, 5'b01101);
            end
        end
        // 4-cycle pulse: accepted, then full replay
        if0.ext_reset_in = 1'b1;
        p = n_e[0] + 1;
        t_as = -1; t_rel = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge aclk);
            if (c == 3) if0.ext_reset_in = 1'b0;
            checks++;
            if (obs0 !== exp_out(0)) begin
                errors++; $display("FAIL ext4_seq edge=%0d got=%b want=%b", n_e[0], obs0, exp_out(0));
            end
            if (t_as < 0 && obs0 == 5'b10010) t_as = n_e[0];
            if (t_as >= 0 && t_rel < 0 && obs0[4] == 1'b0) t_rel = n_e[0];
        end
        checks++;
        if (t_as != p + 7) begin errors++; $display("FAIL ext4_assert_edge got=%0d want=%0d", t_as, p + 7); end
        checks++;
        if (t_rel != p + 24) begin errors++; $display("FAIL ext4_rebus_edge got=%0d want=%0d", t_rel, p + 24); end
    endtask

    task automatic test_lock_drop;
        int p, t_as, t_rel;
        if0.dcm_locked = 1'b0;
        p = n_e[0] + 1;
        t_as = -1; t_rel = -1;
        for (int c = 0; c < 50; c++) begin
            @(negedge aclk);
            if0.dcm_locked = 1'b1;
            checks++;
            if (obs0 !== exp_out(0)) begin
                errors++; $display("FAIL lock_seq edge=%0d got=%b want=%b", n_e[0], obs0, exp_out(0));
            end
            if (t_as < 0 && obs0 == 5'b10010) t_as = n_e[0];
            if (t_as >= 0 && t_rel < 0 && obs0[4] == 1'b0) t_rel = n_e[0];
        end
        checks++;
        if (t_as != p + 3) begin errors++; $display("FAIL lock_assert_edge got=%0d want=%0d", t_as, p + 3); end
        checks++;
        if (t_rel != p + 20) begin errors++; $display("FAIL lock_rebus_edge got=%0d want=%0d", t_rel, p + 20); end
    endtask

    task automatic test_aux_abort;
        int p, per_bad, ord_bad;
        // lock drop restarts the sequence at a known edge; aux lands in REL_IC
        if0.dcm_locked = 1'b0;
        p = n_e[0] + 1;
        per_bad = 0; ord_bad = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge aclk);
            if0.dcm_locked = 1'b1;
            if (n_e[0] == p + 17) if0.aux_reset_in = 1'b0;
            if (n_e[0] == p + 23) if0.aux_reset_in = 1'b1;
            checks++;
            if (obs0 !== exp_out(0)) begin
                errors++; $display("FAIL aux_seq edge=%0d got=%b want=%b", n_e[0], obs0, exp_out(0));
            end
            if (n_e[0] == p + 24) begin
                checks++;
                if (obs0 !== 5'b01010) begin
                    errors++; $display("FAIL aux_in_rel_ic got=%b want=%b", obs0, 5'b01010);
                end
            end
            if (n_e[0] == p + 25) begin
                checks++;
                if (obs0 !== 5'b10010) begin
                    errors++; $display("FAIL aux_abort got=%b want=%b", obs0, 5'b10010);
                end
            end
            if (n_e[0] >= p + 18 && n_e[0] <= p + 51 && obs0[2] !== 1'b0) per_bad++;
            if ((obs0[3] && obs0[4]) || (obs0[2] && !obs0[3]) || (obs0[1] !== ~obs0[2])) ord_bad++;
        end
        checks++;
        if (per_bad != 0) begin errors++; $display("FAIL aux_per_rose count=%0d want=0", per_bad); end
        checks++;
        if (ord_bad != 0) begin errors++; $display("FAIL aux_order count=%0d want=0", ord_bad); end
    endtask

    task automatic test_aresetn_mid_hold;
        int p, t_bus, t_ic, t_per;
        bit rel;
        if0.dcm_locked = 1'b0;
        p = n_e[0] + 1;
        rel = 1'b0;
        t_bus = -1; t_ic = -1; t_per = -1;
        for (int c = 0; c < 50; c++) begin
            @(negedge aclk);
            if0.dcm_locked = 1'b1;
            if (!rel && n_e[0] == p + 10) begin
                aresetn0 = 1'b0;
            end else if (!rel && aresetn0 == 1'b0) begin
                checks++;
                if (obs0 !== 5'b10010) begin
                    errors++; $display("FAIL midhold_reset got=%b want=%b", obs0, 5'b10010);
                end
                aresetn0 = 1'b1;
                rel = 1'b1;
            end else begin
                checks++;
                if (obs0 !== exp_out(0)) begin
                    errors++; $display("FAIL midhold_seq edge=%0d got=%b want=%b", n_e[0], obs0, exp_out(0));
                end
                if (rel && t_bus < 0 && obs0[4] == 1'b0) t_bus = n_e[0];
                if (rel && t_ic < 0 && obs0[3] == 1'b1) t_ic = n_e[0];
                if (rel && t_per < 0 && obs0[2] == 1'b1) t_per = n_e[0];
            end
        end
        checks++;
        if (t_bus != 20 || t_ic != 24 || t_per != 28) begin
            errors++;
            $display("FAIL midhold_release got=%0d/%0d/%0d want=20/24/28", t_bus, t_ic, t_per);
        end
    endtask

    task automatic test_random;
        int mode, len, ord_bad;
        ord_bad = 0;
        for (int b = 0; b < 45; b++) begin
            mode = $urandom_range(0, 4);
            len  = (mode == 0) ? $urandom_range(5, 40) : $urandom_range(1, 6);
            case (mode)
                1: if0.ext_reset_in = 1'b1;
                2: if0.aux_reset_in = 1'b0;
                3: if0.mb_debug_sys_rst = 1'b1;
                4: if0.dcm_locked = 1'b0;
                default: ;
            endcase
            for (int c = 0; c < len; c++) begin
                @(negedge aclk);
                if (c == len - 1) begin
                    if0.ext_reset_in = 1'b0; if0.aux_reset_in = 1'b1;
                    if0.mb_debug_sys_rst = 1'b0; if0.dcm_locked = 1'b1;
                end
                checks++;
                if (obs0 !== exp_out(0)) begin
                    errors++; $display("FAIL random_seq edge=%0d got=%b want=%b", n_e[0], obs0, exp_out(0));
                end
                if ((obs0[3] && obs0[4]) || (obs0[2] && !obs0[3]) || (obs0[1] !== ~obs0[2])) ord_bad++;
            end
        end
        repeat (40) begin
            @(negedge aclk);
            checks++;
            if (obs0 !== exp_out(0)) begin
                errors++; $display("FAIL random_tail edge=%0d got=%b want=%b", n_e[0], obs0, exp_out(0));
            end
        end
        checks++;
        if (ord_bad != 0) begin errors++; $display("FAIL random_order count=%0d want=0", ord_bad); end
    endtask

    task automatic test_sweep;
        int t_bus, t_ic, t_per, p, t_as;
        t_bus = -1; t_ic = -1; t_per = -1;
        aresetn1 = 1'b1;
        repeat (12) begin
            @(negedge aclk);
            checks++;
            if (obs1 !== exp_out(1)) begin
                errors++; $display("FAIL sweep_seq edge=%0d got=%b want=%b", n_e[1], obs1, exp_out(1));
            end
            if (t_bus < 0 && obs1[4] == 1'b0) t_bus = n_e[1];
            if (t_ic < 0 && obs1[3] == 1'b1) t_ic = n_e[1];
            if (t_per < 0 && obs1[2] == 1'b1) t_per = n_e[1];
        end
        checks++;
        if (t_bus != 4 || t_ic != 5 || t_per != 6) begin
            errors++; $display("FAIL sweep_release got=%0d/%0d/%0d want=4/5/6", t_bus, t_ic, t_per);
        end
        // 1-cycle debug pulse, then 1-cycle ext pulse (filter of one)
        for (int s = 0; s < 2; s++) begin
            if (s == 0) if1.mb_debug_sys_rst = 1'b1;
            else        if1.ext_reset_in = 1'b1;
            p = n_e[1] + 1;
            t_as = -1;
            repeat (12) begin
                @(negedge aclk);
                if1.mb_debug_sys_rst = 1'b0;
                if1.ext_reset_in = 1'b0;
                checks++;
                if (obs1 !== exp_out(1)) begin
                    errors++; $display("FAIL sweep_pulse%0d edge=%0d got=%b want=%b", s, n_e[1], obs1, exp_out(1));
                end
                if (t_as < 0 && obs1 == 5'b10010) t_as = n_e[1];
            end
            checks++;
            if (t_as != p + 2 + s) begin
                errors++; $display("FAIL sweep_assert%0d got=%0d want=%0d", s, t_as, p + 2 + s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_ext_filter();
        test_lock_drop();
        test_aux_abort();
        test_aresetn_mid_hold();
        test_random();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
